// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, runs one outstanding read on the
// req/gnt/rvalid instruction bus and presents {addr, inst} to IF/ID.
// A one-entry skid absorbs the single response that can land while the
// presented instruction is held downstream.
module ifu_fetch #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INST_W   = 32,
  parameter logic [ADDR_W-1:0]  RST_ADDR = '0,
  parameter logic [INST_W-1:0]  NOP_INST = INST_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_i,
  output logic              ibus_req_o,
  output logic [ADDR_W-1:0] ibus_addr_o,
  input  logic              ibus_gnt_i,
  input  logic              ibus_rvalid_i,
  input  logic [INST_W-1:0] ibus_rdata_i,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              pipeline_flush_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_STALL} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              kill_q, kill_d;
  logic              req_q, req_d;
  logic              slot_vld_q, slot_vld_d;
  logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
  logic [INST_W-1:0] slot_inst_q, slot_inst_d;
  // Skid occupancy is implied by S_STALL, so only its payload is stored.
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;
  logic [ADDR_W-1:0] seq_addr;

  assign seq_addr = req_addr_q + ADDR_W'(4);

  // Next-state: bus FSM, slot/skid movement, then jump override on top.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    kill_d      = kill_q;
    slot_vld_d  = slot_vld_q;
    slot_addr_d = slot_addr_q;
    slot_inst_d = slot_inst_q;
    skid_addr_d = skid_addr_q;
    skid_inst_d = skid_inst_q;

    // Presented instruction leaves at this edge unless reloaded below.
    if (slot_vld_q && !hold_i) slot_vld_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_addr_d = pc_q;
        state_d    = S_REQ;
      end
      S_REQ: begin
        if (ibus_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ibus_rvalid_i) begin
          if (kill_q) begin
            // Response belongs to a redirected-away fetch.
            kill_d     = 1'b0;
            req_addr_d = pc_q;
            state_d    = S_REQ;
          end else if (!slot_vld_q || !hold_i) begin
            slot_vld_d  = 1'b1;
            slot_addr_d = req_addr_q;
            slot_inst_d = ibus_rdata_i;
            pc_d        = seq_addr;
            req_addr_d  = seq_addr;
            state_d     = S_REQ;
          end else begin
            skid_addr_d = req_addr_q;
            skid_inst_d = ibus_rdata_i;
            pc_d        = seq_addr;
            state_d     = S_STALL;
          end
        end
      end
      S_STALL: begin
        if (!hold_i) begin
          slot_vld_d  = 1'b1;
          slot_addr_d = skid_addr_q;
          slot_inst_d = skid_inst_q;
          req_addr_d  = pc_q;
          state_d     = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (jump_en_i) begin
      pc_d       = jump_addr_i;
      slot_vld_d = 1'b0;
      if ((state_q == S_REQ && ibus_gnt_i) || (state_q == S_WAIT && !ibus_rvalid_i)) begin
        // A transaction is committed on the bus; let it drain and drop it.
        kill_d  = 1'b1;
        state_d = S_WAIT;
      end else begin
        // Nothing in flight (or it completes now): retarget immediately.
        kill_d     = 1'b0;
        req_addr_d = jump_addr_i;
        state_d    = S_REQ;
      end
    end

    req_d = (state_d == S_REQ);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RST_ADDR;
      req_addr_q  <= RST_ADDR;
      kill_q      <= 1'b0;
      req_q       <= 1'b0;
      slot_vld_q  <= 1'b0;
      slot_addr_q <= RST_ADDR;
      slot_inst_q <= NOP_INST;
      skid_addr_q <= RST_ADDR;
      skid_inst_q <= NOP_INST;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      kill_q      <= kill_d;
      req_q       <= req_d;
      slot_vld_q  <= slot_vld_d;
      slot_addr_q <= slot_addr_d;
      slot_inst_q <= slot_inst_d;
      skid_addr_q <= skid_addr_d;
      skid_inst_q <= skid_inst_d;
    end
  end

  assign ibus_req_o       = req_q;
  assign ibus_addr_o      = req_addr_q;
  assign inst_valid_o     = slot_vld_q;
  assign inst_addr_o      = slot_addr_q;
  assign inst_o           = slot_vld_q ? slot_inst_q : NOP_INST;
  assign pipeline_flush_o = ~slot_vld_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: bus responder model, scoreboard queue of expected
// {addr, inst} pairs, and a monitor that checks every presented cycle.
module tb_ifu_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, jump_en, hold;
  logic [31:0] jump_addr;
  logic        ibus_req, ibus_gnt, ibus_rvalid;
  logic [31:0] ibus_addr, ibus_rdata;
  logic [31:0] inst_addr, inst;
  logic        inst_valid, flush;

  int total = 0;
  int bad   = 0;
  int gnt_delay = 0;
  int rv_delay  = 0;
  bit mon_en = 1'b1;

  logic [63:0] exp_q[$];
  logic [31:0] gnt_log[$];

  // bus model state
  int          wcnt = 0;
  int          pcnt = 0;
  bit          pend = 1'b0;
  bit          req_seen = 1'b0;
  logic [31:0] addr_seen = '0;
  logic [31:0] pend_addr = '0;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .jump_en_i(jump_en), .jump_addr_i(jump_addr), .hold_i(hold),
    .ibus_req_o(ibus_req), .ibus_addr_o(ibus_addr), .ibus_gnt_i(ibus_gnt),
    .ibus_rvalid_i(ibus_rvalid), .ibus_rdata_i(ibus_rdata),
    .inst_addr_o(inst_addr), .inst_o(inst), .inst_valid_o(inst_valid),
    .pipeline_flush_o(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_q.push_back({a, a ^ KEY});
  endtask

  task automatic chk_rst();
    chk("rst_req",   ibus_req,   0);
    chk("rst_baddr", ibus_addr,  0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst",  inst,       NOP);
    chk("rst_iaddr", inst_addr,  0);
    chk("rst_flush", flush,      1);
  endtask

  task automatic wait_valid(input logic [31:0] a);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(inst_valid === 1'b1 && inst_addr === a) && n < 60);
    chk("wait_valid", {inst_valid, inst_addr}, {1'b1, a});
  endtask

  // Bus responder: grants after gnt_delay request cycles, answers
  // rv_delay cycles after the handshake, logs every granted address.
  initial begin
    ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = '0;
    forever begin
      @(negedge clk);
      if (ibus_gnt && req_seen) begin
        gnt_log.push_back(addr_seen);
        pend = 1'b1; pend_addr = addr_seen; pcnt = rv_delay;
      end
      ibus_rvalid = 1'b0;
      if (pend) begin
        if (pcnt == 0) begin
          ibus_rvalid = 1'b1; ibus_rdata = pend_addr ^ KEY; pend = 1'b0;
        end else pcnt--;
      end
      if (ibus_req && req_seen && !ibus_gnt && rst_n && !jump_en)
        chk("addr_stable", ibus_addr, addr_seen);
      if (ibus_req) begin
        if (wcnt >= gnt_delay) begin ibus_gnt = 1'b1; wcnt = 0; end
        else begin ibus_gnt = 1'b0; wcnt++; end
      end else begin
        ibus_gnt = 1'b0; wcnt = 0;
      end
      req_seen  = ibus_req;
      addr_seen = ibus_addr;
    end
  end

  // Monitor: compare presented data against the scoreboard head; pop
  // when the slot leaves (consumed, redirected or reset).
  initial begin
    bit mv;
    forever begin
      @(negedge clk);
      mv = inst_valid;
      if (mon_en) begin
        if (inst_valid) begin
          chk("flush_v", flush, 0);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected act=%h exp=none", inst_addr);
          end else chk("sb_front", {inst_addr, inst}, exp_q[0]);
        end else begin
          chk("flush_nv", flush, 1);
          chk("nop_nv", inst, NOP);
        end
      end
      @(posedge clk);
      if (mv && (!hold || jump_en || !rst_n) && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog act=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] gexp [15];
    gexp = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100, 32'h104, 32'h200,
             32'h204, 32'h208, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h0, 32'h4};
    rst_n = 1'b0; hold = 1'b0; jump_en = 1'b0; jump_addr = '0;
    repeat (3) @(negedge clk);
    chk_rst();
    #1 rst_n = 1'b1;
    push(32'h0); push(32'h4);
    // first instruction on the 3rd cycle after release
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lat_valid", inst_valid, (i == 2));
      if (i == 1) #1 gnt_delay = 3;
    end
    chk("lat_addr", inst_addr, 32'h0);

    // 0x4 fetched with a 3-cycle grant delay
    wait_valid(32'h4);
    #1 gnt_delay = 0;
    push(32'h8); push(32'hC);

    // hold 0x8 while 0xC lands in the skid
    wait_valid(32'h8);
    #1 hold = 1'b1;
    repeat (6) @(negedge clk);
    chk("stall_noreq", ibus_req, 0);
    chk("held_addr", inst_addr, 32'h8);
    #1 hold = 1'b0;
    @(negedge clk);
    chk("skid_out", {inst_valid, inst_addr}, {1'b1, 32'hC});
    chk("req_10", {ibus_req, ibus_addr}, {1'b1, 32'h10});
    #1 rv_delay = 2;

    // jump while waiting for 0x10
    @(negedge clk);
    chk("wait_10", ibus_req, 0);
    #1 jump_en = 1'b1; jump_addr = 32'h100;
    push(32'h100);
    @(negedge clk);
    #1 jump_en = 1'b0;
    @(negedge clk);
    chk("kill_wait", {ibus_req, inst_valid}, 0);
    @(negedge clk);
    chk("req_100", {ibus_req, ibus_addr}, {1'b1, 32'h100});
    chk("kill_nv", inst_valid, 0);
    #1 rv_delay = 0;

    // jump with slot held and skid full
    wait_valid(32'h100);
    #1 hold = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall2", ibus_req, 0);
    #1 jump_en = 1'b1; jump_addr = 32'h200;
    @(negedge clk);
    chk("jmp_clr", inst_valid, 0);
    chk("req_200", {ibus_req, ibus_addr}, {1'b1, 32'h200});
    #1 jump_en = 1'b0; hold = 1'b0;
    push(32'h200); push(32'h204);

    // jump in REQ with grant the same cycle, then wrap-around
    wait_valid(32'h204);
    #1 jump_en = 1'b1; jump_addr = 32'hFFFF_FFFC;
    push(32'hFFFF_FFFC); push(32'h0);
    @(negedge clk);
    chk("jmp_gnt_nv", inst_valid, 0);
    #1 jump_en = 1'b0;
    wait_valid(32'hFFFF_FFFC);
    chk("wrap", {ibus_req, ibus_addr}, {1'b1, 32'h0});
    wait_valid(32'h0);
    #1 rv_delay = 1;

    // reset in WAIT; the stale response arrives while in IDLE
    @(negedge clk);
    chk("wait_4", ibus_req, 0);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_rst();
    #1 rst_n = 1'b1; rv_delay = 0;
    push(32'h0); push(32'h4);
    wait_valid(32'h0);
    wait_valid(32'h4);
    @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    #1 mon_en = 1'b0;
    chk("gnt_cnt", (gnt_log.size() >= 15), 1);
    for (int i = 0; i < 15; i++)
      if (i < gnt_log.size()) chk("gnt_log", gnt_log[i], gexp[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
